// File: rtl/hazard_scoreboard.sv
// Scoreboard hazard unit for the in-order MIPS pipeline: tracks in-flight GPR writers
// from X (stage 0) to W (stage NUM_STAGES-1) and derives forwarding selects and the decode stall.
module hazard_scoreboard #(
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned NUM_STAGES = 3,
    parameter int unsigned LOAD_STAGE = 2,
    parameter int unsigned FWD_W      = $clog2(NUM_STAGES + 1),
    parameter int unsigned CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  d_valid,
    input  logic [REG_ADDR_W-1:0] d_rs,
    input  logic [REG_ADDR_W-1:0] d_rt,
    input  logic                  d_use_rs,
    input  logic                  d_use_rt,
    input  logic                  d_early,
    input  logic                  d_wr_en,
    input  logic [REG_ADDR_W-1:0] d_wr_addr,
    input  logic                  d_is_load,
    input  logic                  flush,
    input  logic                  freeze,
    output logic                  d_stall,
    output logic [FWD_W-1:0]      d_fwd_rs,
    output logic [FWD_W-1:0]      d_fwd_rt,
    output logic [FWD_W-1:0]      x_fwd_alu_src1,
    output logic [FWD_W-1:0]      x_fwd_alu_src2,
    output logic [CNT_W-1:0]      stall_cycles
);

    logic [NUM_STAGES-1:0]                 vld_q, vld_d;
    logic [NUM_STAGES-1:0]                 ld_q, ld_d;
    logic [NUM_STAGES-1:0][REG_ADDR_W-1:0] addr_q, addr_d;
    logic [FWD_W-1:0]                      xs1_q, xs1_d;
    logic [FWD_W-1:0]                      xs2_q, xs2_d;
    logic [CNT_W-1:0]                      cnt_q, cnt_d;

    logic [NUM_STAGES-1:0] match_rs, match_rt;
    logic [NUM_STAGES-1:0] first_rs, first_rt;
    logic                  hit_rs, hit_rt;
    logic                  ld_rs, ld_rt;
    logic [FWD_W-1:0]      idx_rs, idx_rt;
    logic [FWD_W-1:0]      xsel_rs, xsel_rt;
    logic                  stall_rs, stall_rt;
    logic                  hz_stall;
    logic                  issue;
    logic                  new_vld;

    function automatic logic [FWD_W-1:0] oh_index(input logic [NUM_STAGES-1:0] oh);
        logic [FWD_W-1:0] idx;
        idx = '0;
        for (int unsigned j = 0; j < NUM_STAGES; j++) begin
            if (oh[j]) idx = idx | FWD_W'(j);
        end
        return idx;
    endfunction

    // A consumer in X reads its operand one stage later than a decode-time consumer.
    function automatic logic src_stall(input logic hit, input logic is_ld,
                                       input logic [FWD_W-1:0] idx, input logic early);
        int unsigned rdy;
        int unsigned stg;
        rdy = is_ld ? LOAD_STAGE : 32'd1;
        stg = 32'(idx);
        if (!early) stg = stg + 32'd1;
        return hit && (stg < rdy);
    endfunction

    always_comb begin
        match_rs = '0;
        match_rt = '0;
        for (int unsigned j = 0; j < NUM_STAGES; j++) begin
            match_rs[j] = d_use_rs && (d_rs != '0) && vld_q[j] && (addr_q[j] == d_rs);
            match_rt[j] = d_use_rt && (d_rt != '0) && vld_q[j] && (addr_q[j] == d_rt);
        end
        // Isolating the lowest set bit selects the youngest writer.
        first_rs = match_rs & (~match_rs + 1'b1);
        first_rt = match_rt & (~match_rt + 1'b1);
    end

    always_comb begin
        hit_rs   = |match_rs;
        hit_rt   = |match_rt;
        idx_rs   = oh_index(first_rs);
        idx_rt   = oh_index(first_rt);
        ld_rs    = |(first_rs & ld_q);
        ld_rt    = |(first_rt & ld_q);
        stall_rs = src_stall(hit_rs, ld_rs, idx_rs, d_early);
        stall_rt = src_stall(hit_rt, ld_rt, idx_rt, d_early);
        xsel_rs  = (hit_rs && (idx_rs != FWD_W'(NUM_STAGES - 1))) ? idx_rs + 1'b1 : '0;
        xsel_rt  = (hit_rt && (idx_rt != FWD_W'(NUM_STAGES - 1))) ? idx_rt + 1'b1 : '0;
        hz_stall = d_valid && !flush && (stall_rs || stall_rt);
        issue    = d_valid && !flush && !hz_stall;
        new_vld  = issue && d_wr_en && (d_wr_addr != '0);
    end

    always_comb begin
        d_stall        = hz_stall || freeze;
        d_fwd_rs       = idx_rs;
        d_fwd_rt       = idx_rt;
        x_fwd_alu_src1 = xs1_q;
        x_fwd_alu_src2 = xs2_q;
        stall_cycles   = cnt_q;
    end

    always_comb begin
        vld_d  = vld_q;
        ld_d   = ld_q;
        addr_d = addr_q;
        xs1_d  = xs1_q;
        xs2_d  = xs2_q;
        cnt_d  = cnt_q;
        if (!freeze) begin
            vld_d  = {vld_q[NUM_STAGES-2:0], new_vld};
            ld_d   = {ld_q[NUM_STAGES-2:0], d_is_load};
            addr_d = {addr_q[NUM_STAGES-2:0], d_wr_addr};
            xs1_d  = (issue && !d_early) ? xsel_rs : '0;
            xs2_d  = (issue && !d_early) ? xsel_rt : '0;
            if (hz_stall && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            vld_q  <= '0;
            ld_q   <= '0;
            addr_q <= '0;
            xs1_q  <= '0;
            xs2_q  <= '0;
            cnt_q  <= '0;
        end else begin
            vld_q  <= vld_d;
            ld_q   <= ld_d;
            addr_q <= addr_d;
            xs1_q  <= xs1_d;
            xs2_q  <= xs2_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: two configurations (3 stages/load@2/16-bit counter and
// 4 stages/load@3/2-bit counter) driven in parallel, checked against a writer-list model.
module tb_hazard_scoreboard;

    localparam int RW  = 5;
    localparam int NSA = 3;
    localparam int LSA = 2;
    localparam int CWA = 16;
    localparam int NSB = 4;
    localparam int LSB = 3;
    localparam int CWB = 2;
    localparam int FWA = $clog2(NSA + 1);
    localparam int FWB = $clog2(NSB + 1);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset, d_valid, d_use_rs, d_use_rt, d_early, d_wr_en, d_is_load, flush, freeze;
    logic [RW-1:0] d_rs, d_rt, d_wr_addr;

    logic           a_stall, b_stall;
    logic [FWA-1:0] a_frs, a_frt, a_xs1, a_xs2;
    logic [FWB-1:0] b_frs, b_frt, b_xs1, b_xs2;
    logic [CWA-1:0] a_cnt;
    logic [CWB-1:0] b_cnt;

    hazard_scoreboard #(.REG_ADDR_W(RW), .NUM_STAGES(NSA), .LOAD_STAGE(LSA), .CNT_W(CWA)) dut_a (
        .clk(clk), .reset(reset), .d_valid(d_valid), .d_rs(d_rs), .d_rt(d_rt),
        .d_use_rs(d_use_rs), .d_use_rt(d_use_rt), .d_early(d_early), .d_wr_en(d_wr_en),
        .d_wr_addr(d_wr_addr), .d_is_load(d_is_load), .flush(flush), .freeze(freeze),
        .d_stall(a_stall), .d_fwd_rs(a_frs), .d_fwd_rt(a_frt),
        .x_fwd_alu_src1(a_xs1), .x_fwd_alu_src2(a_xs2), .stall_cycles(a_cnt));

    hazard_scoreboard #(.REG_ADDR_W(RW), .NUM_STAGES(NSB), .LOAD_STAGE(LSB), .CNT_W(CWB)) dut_b (
        .clk(clk), .reset(reset), .d_valid(d_valid), .d_rs(d_rs), .d_rt(d_rt),
        .d_use_rs(d_use_rs), .d_use_rt(d_use_rt), .d_early(d_early), .d_wr_en(d_wr_en),
        .d_wr_addr(d_wr_addr), .d_is_load(d_is_load), .flush(flush), .freeze(freeze),
        .d_stall(b_stall), .d_fwd_rs(b_frs), .d_fwd_rt(b_frt),
        .x_fwd_alu_src1(b_xs1), .x_fwd_alu_src2(b_xs2), .stall_cycles(b_cnt));

    int errors = 0;
    int checks = 0;

    // Model: per configuration, an unordered list of in-flight writers with their current stage.
    int ns[2];
    int ls[2];
    int cmax[2];
    int m_n[2];
    int m_addr[2][8];
    bit m_ld[2][8];
    int m_stg[2][8];
    bit e_stall[2];
    bit e_hz[2];
    int e_frs[2], e_frt[2], e_xs1[2], e_xs2[2], e_cnt[2];

    function automatic int find_writer(int c, int src, int maxstg);
        int best = -1;
        for (int i = 0; i < m_n[c]; i++) begin
            if (m_addr[c][i] == src && m_stg[c][i] <= maxstg &&
                (best < 0 || m_stg[c][i] < m_stg[c][best])) best = i;
        end
        return best;
    endfunction

    task automatic src_eval(input int c, input bit use_s, input int src, output int fwd, output bit st);
        int w;
        int need;
        fwd = 0;
        st  = 1'b0;
        if (use_s && src != 0) begin
            w = find_writer(c, src, ns[c] - 1);
            if (w >= 0) begin
                need = m_ld[c][w] ? ls[c] : 1;
                fwd  = m_stg[c][w];
                st   = d_early ? (m_stg[c][w] < need) : (m_stg[c][w] + 1 < need);
            end
        end
    endtask

    task automatic model_comb(input int c);
        int fr, ft;
        bit ss, st;
        src_eval(c, d_use_rs, int'(d_rs), fr, ss);
        src_eval(c, d_use_rt, int'(d_rt), ft, st);
        e_frs[c]   = fr;
        e_frt[c]   = ft;
        e_hz[c]    = d_valid && !flush && (ss || st);
        e_stall[c] = e_hz[c] || freeze;
    endtask

    task automatic model_adv(input int c);
        int w, k;
        bit issue;
        if (reset) begin
            m_n[c] = 0; e_xs1[c] = 0; e_xs2[c] = 0; e_cnt[c] = 0;
            return;
        end
        if (freeze) return;
        if (e_hz[c] && e_cnt[c] < cmax[c]) e_cnt[c]++;
        issue    = d_valid && !flush && !e_hz[c];
        e_xs1[c] = 0;
        e_xs2[c] = 0;
        if (issue && !d_early) begin
            if (d_use_rs && d_rs != 0) begin
                w = find_writer(c, int'(d_rs), ns[c] - 2);
                if (w >= 0) e_xs1[c] = m_stg[c][w] + 1;
            end
            if (d_use_rt && d_rt != 0) begin
                w = find_writer(c, int'(d_rt), ns[c] - 2);
                if (w >= 0) e_xs2[c] = m_stg[c][w] + 1;
            end
        end
        k = 0;
        for (int i = 0; i < m_n[c]; i++) begin
            if (m_stg[c][i] + 1 < ns[c]) begin
                m_addr[c][k] = m_addr[c][i];
                m_ld[c][k]   = m_ld[c][i];
                m_stg[c][k]  = m_stg[c][i] + 1;
                k++;
            end
        end
        m_n[c] = k;
        if (issue && d_wr_en && d_wr_addr != 0) begin
            m_addr[c][k] = int'(d_wr_addr);
            m_ld[c][k]   = d_is_load;
            m_stg[c][k]  = 0;
            m_n[c]       = k + 1;
        end
    endtask

    task automatic cyc();
        model_comb(0);
        model_comb(1);
        @(posedge clk);
        model_adv(0);
        model_adv(1);
        #1;
    endtask

    task automatic set_instr(input bit v, input int rs, input int rt, input bit urs, input bit urt,
                             input bit early, input bit we, input int wa, input bit ld);
        d_valid = v; d_rs = RW'(rs); d_rt = RW'(rt); d_use_rs = urs; d_use_rt = urt;
        d_early = early; d_wr_en = we; d_wr_addr = RW'(wa); d_is_load = ld;
        #1;
    endtask

    task automatic bubble();
        set_instr(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        reset = 1'b1; freeze = 1'b0; flush = 1'b0;
        bubble();
        cyc();
        cyc();
        reset = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; freeze = 1'b0; flush = 1'b0;
        set_instr(1, 5, 6, 1, 1, 0, 1, 5, 1);
        cyc();
        cyc();
        checks++; if (a_xs1 !== 2'd0) begin errors++; $display("FAIL rst_xs1: got %0d expected 0", a_xs1); end
        checks++; if (a_xs2 !== 2'd0) begin errors++; $display("FAIL rst_xs2: got %0d expected 0", a_xs2); end
        checks++; if (a_cnt !== 16'd0) begin errors++; $display("FAIL rst_cnt: got %0d expected 0", a_cnt); end
        checks++; if (b_cnt !== 2'd0) begin errors++; $display("FAIL rst_cnt_b: got %0d expected 0", b_cnt); end
        reset = 1'b0;
        set_instr(1, 5, 6, 1, 1, 1, 0, 0, 0);
        checks++; if (a_stall !== 1'b0) begin errors++; $display("FAIL rst_stall: got %0d expected 0", a_stall); end
        checks++; if (a_frs !== 2'd0) begin errors++; $display("FAIL rst_frs: got %0d expected 0", a_frs); end
        checks++; if (b_frt !== 3'd0) begin errors++; $display("FAIL rst_frt_b: got %0d expected 0", b_frt); end
        freeze = 1'b1;
        #1;
        checks++; if (a_stall !== 1'b1) begin errors++; $display("FAIL rst_frz_stall: got %0d expected 1", a_stall); end
        freeze = 1'b0;
        bubble();
    endtask

    task automatic test_load_use();
        do_reset();
        set_instr(1, 0, 0, 0, 0, 0, 1, 5, 1);                // lw r5
        checks++; if (a_stall !== 1'b0) begin errors++; $display("FAIL lu_lw_stall: got %0d expected 0", a_stall); end
        cyc();
        set_instr(1, 5, 1, 1, 1, 0, 1, 6, 0);                // add r6,r5,r1
        checks++; if (a_stall !== 1'b1) begin errors++; $display("FAIL lu_stall: got %0d expected 1", a_stall); end
        cyc();
        checks++; if (a_cnt !== 16'd1) begin errors++; $display("FAIL lu_cnt: got %0d expected 1", a_cnt); end
        checks++; if (a_xs1 !== 2'd0) begin errors++; $display("FAIL lu_bubble_xs1: got %0d expected 0", a_xs1); end
        checks++; if (a_stall !== 1'b0) begin errors++; $display("FAIL lu_release: got %0d expected 0", a_stall); end
        cyc();
        checks++; if (a_xs1 !== 2'd2) begin errors++; $display("FAIL lu_xs1: got %0d expected 2", a_xs1); end
        checks++; if (a_xs2 !== 2'd0) begin errors++; $display("FAIL lu_xs2: got %0d expected 0", a_xs2); end
        checks++; if (a_cnt !== 16'd1) begin errors++; $display("FAIL lu_cnt2: got %0d expected 1", a_cnt); end
        bubble();
    endtask

    task automatic test_alu_b2b();
        do_reset();
        set_instr(1, 1, 2, 1, 1, 0, 1, 3, 0);                // add r3,r1,r2
        cyc();
        set_instr(1, 3, 3, 1, 1, 0, 1, 4, 0);                // sub r4,r3,r3
        checks++; if (a_stall !== 1'b0) begin errors++; $display("FAIL b2b_stall: got %0d expected 0", a_stall); end
        checks++; if (b_stall !== 1'b0) begin errors++; $display("FAIL b2b_stall_b: got %0d expected 0", b_stall); end
        cyc();
        checks++; if (a_xs1 !== 2'd1) begin errors++; $display("FAIL b2b_xs1: got %0d expected 1", a_xs1); end
        checks++; if (a_xs2 !== 2'd1) begin errors++; $display("FAIL b2b_xs2: got %0d expected 1", a_xs2); end
        checks++; if (b_xs2 !== 3'd1) begin errors++; $display("FAIL b2b_xs2_b: got %0d expected 1", b_xs2); end
        bubble();
    endtask

    task automatic test_branch_alu();
        do_reset();
        set_instr(1, 1, 1, 1, 1, 0, 1, 2, 0);                // add r2,r1,r1
        cyc();
        set_instr(1, 2, 7, 1, 1, 1, 0, 0, 0);                // beq r2,r7
        checks++; if (a_stall !== 1'b1) begin errors++; $display("FAIL br_stall: got %0d expected 1", a_stall); end
        cyc();
        checks++; if (a_cnt !== 16'd1) begin errors++; $display("FAIL br_cnt: got %0d expected 1", a_cnt); end
        checks++; if (a_stall !== 1'b0) begin errors++; $display("FAIL br_release: got %0d expected 0", a_stall); end
        checks++; if (a_frs !== 2'd1) begin errors++; $display("FAIL br_frs: got %0d expected 1", a_frs); end
        checks++; if (a_frt !== 2'd0) begin errors++; $display("FAIL br_frt: got %0d expected 0", a_frt); end
        cyc();
        checks++; if (a_xs1 !== 2'd0) begin errors++; $display("FAIL br_xs1_early: got %0d expected 0", a_xs1); end
        bubble();
    endtask

    task automatic branch_load_b(input int reg_n, output int nst);
        set_instr(1, 0, 0, 0, 0, 0, 1, reg_n, 1);            // lw rN
        cyc();
        set_instr(1, reg_n, 0, 1, 1, 1, 0, 0, 0);            // beq rN,r0
        nst = 0;
        for (int i = 0; i < 8 && b_stall; i++) begin
            cyc();
            nst++;
        end
    endtask

    task automatic test_branch_load();
        int nst;
        do_reset();
        branch_load_b(9, nst);
        checks++; if (nst !== 3) begin errors++; $display("FAIL brld_stalls: got %0d expected 3", nst); end
        checks++; if (b_frs !== 3'd3) begin errors++; $display("FAIL brld_frs: got %0d expected 3", b_frs); end
        checks++; if (b_frt !== 3'd0) begin errors++; $display("FAIL brld_frt: got %0d expected 0", b_frt); end
        checks++; if (b_cnt !== 2'd3) begin errors++; $display("FAIL brld_cnt: got %0d expected 3", b_cnt); end
        bubble();
    endtask

    task automatic test_freeze();
        do_reset();
        set_instr(1, 1, 0, 1, 0, 0, 1, 5, 0);                // add r5,r1,r0
        cyc();
        set_instr(1, 5, 0, 1, 0, 0, 1, 7, 1);                // lw r7,0(r5)
        cyc();
        checks++; if (a_xs1 !== 2'd1) begin errors++; $display("FAIL frz_pre_xs1: got %0d expected 1", a_xs1); end
        set_instr(1, 7, 0, 1, 0, 0, 1, 8, 0);                // add r8,r7,r0
        checks++; if (a_stall !== 1'b1) begin errors++; $display("FAIL frz_pre_stall: got %0d expected 1", a_stall); end
        freeze = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++; if (a_stall !== 1'b1) begin errors++; $display("FAIL frz_stall: got %0d expected 1", a_stall); end
            cyc();
            checks++; if (a_xs1 !== 2'd1) begin errors++; $display("FAIL frz_xs1: got %0d expected 1", a_xs1); end
            checks++; if (a_cnt !== 16'd0) begin errors++; $display("FAIL frz_cnt: got %0d expected 0", a_cnt); end
        end
        freeze = 1'b0;
        #1;
        checks++; if (a_stall !== 1'b1) begin errors++; $display("FAIL frz_held: got %0d expected 1", a_stall); end
        cyc();
        checks++; if (a_cnt !== 16'd1) begin errors++; $display("FAIL frz_cnt_post: got %0d expected 1", a_cnt); end
        checks++; if (a_xs1 !== 2'd0) begin errors++; $display("FAIL frz_bubble: got %0d expected 0", a_xs1); end
        checks++; if (a_stall !== 1'b0) begin errors++; $display("FAIL frz_release: got %0d expected 0", a_stall); end
        cyc();
        checks++; if (a_xs1 !== 2'd2) begin errors++; $display("FAIL frz_xs1_post: got %0d expected 2", a_xs1); end
        bubble();
    endtask

    task automatic test_flush();
        do_reset();
        set_instr(1, 0, 0, 0, 0, 0, 1, 5, 1);                // lw r5
        cyc();
        flush = 1'b1;
        set_instr(1, 5, 0, 1, 0, 0, 1, 6, 0);                // add r6,r5 (flushed)
        checks++; if (a_stall !== 1'b0) begin errors++; $display("FAIL fl_stall: got %0d expected 0", a_stall); end
        cyc();
        flush = 1'b0;
        checks++; if (a_cnt !== 16'd0) begin errors++; $display("FAIL fl_cnt: got %0d expected 0", a_cnt); end
        checks++; if (a_xs1 !== 2'd0) begin errors++; $display("FAIL fl_xs1: got %0d expected 0", a_xs1); end
        set_instr(1, 6, 5, 1, 1, 1, 0, 0, 0);                // beq r6,r5
        checks++; if (a_frs !== 2'd0) begin errors++; $display("FAIL fl_no_entry: got %0d expected 0", a_frs); end
        checks++; if (a_frt !== 2'd1) begin errors++; $display("FAIL fl_frt: got %0d expected 1", a_frt); end
        checks++; if (a_stall !== 1'b1) begin errors++; $display("FAIL fl_br_stall: got %0d expected 1", a_stall); end
        flush = 1'b1;
        #1;
        checks++; if (a_stall !== 1'b0) begin errors++; $display("FAIL fl_mask: got %0d expected 0", a_stall); end
        freeze = 1'b1;
        #1;
        checks++; if (a_stall !== 1'b1) begin errors++; $display("FAIL fl_frz: got %0d expected 1", a_stall); end
        freeze = 1'b0;
        flush  = 1'b0;
        do_reset();
        set_instr(1, 1, 0, 1, 0, 0, 1, 0, 1);                // load into r0
        cyc();
        set_instr(1, 0, 0, 1, 1, 1, 0, 0, 0);                // beq r0,r0
        checks++; if (a_stall !== 1'b0) begin errors++; $display("FAIL r0_stall: got %0d expected 0", a_stall); end
        checks++; if (a_frs !== 2'd0) begin errors++; $display("FAIL r0_frs: got %0d expected 0", a_frs); end
        bubble();
    endtask

    task automatic test_saturation();
        int n1, n2;
        do_reset();
        branch_load_b(9, n1);
        cyc();
        branch_load_b(10, n2);
        checks++; if (n1 + n2 !== 6) begin errors++; $display("FAIL sat_stalls: got %0d expected 6", n1 + n2); end
        checks++; if (b_cnt !== 2'd3) begin errors++; $display("FAIL sat_cnt: got %0d expected 3", b_cnt); end
        bubble();
    endtask

    task automatic test_random();
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            reset  = ($urandom_range(0, 199) == 0);
            freeze = ($urandom_range(0, 9) == 0);
            flush  = ($urandom_range(0, 11) == 0);
            set_instr($urandom_range(0, 7) != 0, $urandom_range(0, 3), $urandom_range(0, 3),
                      $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 4) == 0,
                      $urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 2) == 0);
            model_comb(0);
            model_comb(1);
            checks++; if (a_stall !== e_stall[0]) begin errors++; $display("FAIL rnd_stall_a: got %0d expected %0d", a_stall, e_stall[0]); end
            checks++; if (b_stall !== e_stall[1]) begin errors++; $display("FAIL rnd_stall_b: got %0d expected %0d", b_stall, e_stall[1]); end
            checks++; if (a_frs !== FWA'(e_frs[0])) begin errors++; $display("FAIL rnd_frs_a: got %0d expected %0d", a_frs, e_frs[0]); end
            checks++; if (a_frt !== FWA'(e_frt[0])) begin errors++; $display("FAIL rnd_frt_a: got %0d expected %0d", a_frt, e_frt[0]); end
            checks++; if (b_frs !== FWB'(e_frs[1])) begin errors++; $display("FAIL rnd_frs_b: got %0d expected %0d", b_frs, e_frs[1]); end
            checks++; if (b_frt !== FWB'(e_frt[1])) begin errors++; $display("FAIL rnd_frt_b: got %0d expected %0d", b_frt, e_frt[1]); end
            cyc();
            checks++; if (a_xs1 !== FWA'(e_xs1[0])) begin errors++; $display("FAIL rnd_xs1_a: got %0d expected %0d", a_xs1, e_xs1[0]); end
            checks++; if (a_xs2 !== FWA'(e_xs2[0])) begin errors++; $display("FAIL rnd_xs2_a: got %0d expected %0d", a_xs2, e_xs2[0]); end
            checks++; if (b_xs1 !== FWB'(e_xs1[1])) begin errors++; $display("FAIL rnd_xs1_b: got %0d expected %0d", b_xs1, e_xs1[1]); end
            checks++; if (b_xs2 !== FWB'(e_xs2[1])) begin errors++; $display("FAIL rnd_xs2_b: got %0d expected %0d", b_xs2, e_xs2[1]); end
            checks++; if (a_cnt !== CWA'(e_cnt[0])) begin errors++; $display("FAIL rnd_cnt_a: got %0d expected %0d", a_cnt, e_cnt[0]); end
            checks++; if (b_cnt !== CWB'(e_cnt[1])) begin errors++; $display("FAIL rnd_cnt_b: got %0d expected %0d", b_cnt, e_cnt[1]); end
        end
        reset  = 1'b0;
        freeze = 1'b0;
        flush  = 1'b0;
        bubble();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        ns[0] = NSA; ls[0] = LSA; cmax[0] = (1 << CWA) - 1;
        ns[1] = NSB; ls[1] = LSB; cmax[1] = (1 << CWB) - 1;
        m_n[0] = 0; m_n[1] = 0;
        reset = 1'b1; freeze = 1'b0; flush = 1'b0;
        bubble();
        test_reset();
        test_load_use();
        test_alu_b2b();
        test_branch_alu();
        test_branch_load();
        test_freeze();
        test_flush();
        test_saturation();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
